led_mode_sequencer: RTL and testbench
=====================================

// Module: led_mode_sequencer
// PURPOSE
//  Front-end controller for the LED frequency blinker. Debounces the two frequency-select switches
//  and drives the blinker's enable/select inputs. Every frequency change goes through a blanking
//  gap (enable low) so the blinker never sees a glitchy select. An optional mode auto-cycles the
//  four frequencies. Sits between board switches and tutorial_led_blink.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive differing samples needed to accept a new switch level (>=1)
//  BLANK_CYCLES     2   cycles o_enable is held low around every select change (>=1)
//  DWELL_CYCLES     16  RUN cycles per frequency in auto-cycle mode (>=2)
//  CNT_W            8   width of internal counters; must hold max(DEBOUNCE,BLANK,DWELL)
// PORTS
//  i_clock     in   1  single clock, rising edge
//  i_reset     in   1  synchronous reset, active-high
//  i_enable    in   1  system enable (already synchronous, not debounced)
//  i_switch_1  in   1  raw select switch, bit 0 (async, bouncing)
//  i_switch_2  in   1  raw select switch, bit 1 (async, bouncing)
//  i_auto      in   1  1 = auto-cycle select; ignored unless LED_SEQ_AUTO_CYCLE_EN
//  o_enable    out  1  to blinker i_enable
//  o_switch_1  out  1  to blinker i_switch_1 (cur_sel[0])
//  o_switch_2  out  1  to blinker i_switch_2 (cur_sel[1])
//  o_busy      out  1  high while in S_BLANK
// BEHAVIOUR
//  Reset: all flops cleared; state S_OFF; o_enable=0, o_switch_1=0, o_switch_2=0, o_busy=0.
//  Debounce (per switch): 2-flop synchronizer; cnt counts consecutive sync samples != db; a matching
//   sample clears cnt; when cnt reaches DEBOUNCE_CYCLES, db<=sample, cnt<=0. db changes on the
//   (2+DEBOUNCE_CYCLES)th edge after a clean raw change. Bounce shorter than this is rejected.
//  target = {db_2,db_1} (manual), or auto_sel in auto mode.
//  FSM (registered outputs, all updates on i_clock rising edge):
//   S_OFF  : o_enable=0. i_enable=1 -> S_BLANK, pend<=target, bcnt<=0.
//   S_BLANK: o_enable=0, o_busy=1, outputs hold cur_sel. i_enable=0 -> S_OFF (pend dropped).
//            target!=pend -> pend<=target, bcnt<=0 (gap restarts). bcnt==BLANK_CYCLES-1 ->
//            cur_sel<=pend, -> S_RUN. Else bcnt++.
//   S_RUN  : o_enable=1, outputs = cur_sel. i_enable=0 -> S_OFF (wins over select change).
//            target!=cur_sel -> S_BLANK, pend<=target, bcnt<=0.
//  Latency: i_enable rise -> o_enable high after exactly BLANK_CYCLES+1 edges (S_OFF->BLANK->RUN).
//   i_enable fall -> o_enable low on next edge. cur_sel changes only on BLANK->RUN edge.
//  Switches move the select only while i_enable=1; in S_OFF cur_sel holds its last value.
//  i_reset mid-BLANK or mid-RUN: immediate return to reset values; debounce state also cleared.
// CONFIGURATION
//  LED_SEQ_AUTO_CYCLE_EN defined: when i_auto=1, auto_sel (2b) increments (3 wraps to 0) after
//   DWELL_CYCLES consecutive S_RUN cycles; dwell counter clears on leaving S_RUN. auto_sel clears
//   on reset. i_auto 1->0 returns target to the switches (normal blank-gap change if different).
//  Not defined: no auto_sel/dwell logic; i_auto unconnected internally; target = switches only.
// STRUCTURE
//  led_seq_pkg: state enum {S_OFF,S_BLANK,S_RUN}, sel encoding constants SEL_F0..SEL_F3 (2b).
//  Sub-module led_switch_debounce (sync + counter, param DEBOUNCE_CYCLES, CNT_W), one instance per
//   switch. FSM, blank counter and optional auto/dwell logic live in led_mode_sequencer.
// TESTING (DEBOUNCE_CYCLES=4, BLANK_CYCLES=2, DWELL_CYCLES=16; 10 ns clock)
//  1 Reset held 3 cycles with switches=2'b11, i_enable=1 -> all outputs 0 during reset; after
//    release o_enable=1 exactly 3 edges later, selects still 0 until debounce, then blank+switch.
//  2 i_enable=1, switches 00->01 clean -> o_busy high 2 cycles starting edge 7 after change,
//    o_enable low for those 2 cycles, then o_switch_1=1, o_enable=1.
//  3 switch_1 bounces 0/1 every 2 cycles for 20 cycles then settles 0 -> no o_busy, no output change.
//  4 In S_BLANK (after 00->01), switch_2 lands 1 -> bcnt restarts; final o_switch_{2,1}=11 after
//    one extended gap, no intermediate 01 ever driven with o_enable=1.
//  5 In S_RUN, drop i_enable while switches change same cycle -> o_enable=0 next edge, S_OFF,
//    cur_sel unchanged; reassert -> 2-cycle blank then RUN with new select.
//  6 (LED_SEQ_AUTO_CYCLE_EN) i_auto=1, i_enable=1 -> select steps 00,01,10,11,00 with 2-cycle
//    blank between each 16-cycle dwell; undefined macro -> select stays at switches.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer.
//   state_t   : sequencer FSM states
//   SEL_F0..3 : 2-bit frequency select encodings driven to the blinker
//   sel_next  : auto-cycle successor (F3 wraps to F0)
package led_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [1:0] SEL_F0 = 2'b00;
  localparam logic [1:0] SEL_F1 = 2'b01;
  localparam logic [1:0] SEL_F2 = 2'b10;
  localparam logic [1:0] SEL_F3 = 2'b11;

  function automatic logic [1:0] sel_next(input logic [1:0] sel);
    return (sel == SEL_F3) ? SEL_F0 : sel + 2'd1;
  endfunction

endpackage

// File: rtl/led_switch_debounce.sv
// Single-switch debouncer: 2-flop synchronizer followed by a run-length
// counter. The debounced level flips only after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with it; any agreeing sample clears the
// run. A clean raw edge therefore shows on o_db after 2+DEBOUNCE_CYCLES edges.
// Ports:
//   i_clock  clock, rising edge
//   i_reset  synchronous reset, active-high (clears all state)
//   i_raw    raw asynchronous switch input
//   o_db     debounced level
module led_switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d  = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_db = db_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Front-end controller for the LED frequency blinker. Debounces the two
// select switches and drives the blinker enable/select, inserting an
// enable-low blanking gap around every select change so the blinker never
// sees a select move while enabled.
// Optional feature: define LED_SEQ_AUTO_CYCLE_EN to let i_auto=1 step the
// select through F0..F3, DWELL_CYCLES RUN cycles per frequency.
// Ports:
//   i_clock     clock, rising edge
//   i_reset     synchronous reset, active-high
//   i_enable    system enable (synchronous)
//   i_switch_1  raw select switch bit 0
//   i_switch_2  raw select switch bit 1
//   i_auto      auto-cycle request (unused unless LED_SEQ_AUTO_CYCLE_EN)
//   o_enable    blinker enable (high only in RUN)
//   o_switch_1  blinker select bit 0
//   o_switch_2  blinker select bit 1
//   o_busy      high while a blanking gap is in progress
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLANK_CYCLES    = 2,
  parameter int DWELL_CYCLES    = 16,
  parameter int CNT_W           = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_switch_1,
  input  logic i_switch_2,
  input  logic i_auto,
  output logic o_enable,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [1:0] sw_raw, sw_db;
  logic [1:0] target;

  assign sw_raw = {i_switch_2, i_switch_1};

  led_switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [1:0] (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_raw  (sw_raw),
    .o_db   (sw_db)
  );

  state_t           state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             o_enable_q, o_busy_q;
  logic [1:0]       o_sel_q;

`ifdef LED_SEQ_AUTO_CYCLE_EN
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       auto_sel_q, auto_sel_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  // Dwell counts only uninterrupted RUN cycles in auto mode; any other
  // cycle (blanking, off, manual mode) restarts it.
  always_comb begin
    auto_sel_d = auto_sel_q;
    dwell_d    = '0;
    if (state_q == S_RUN && i_auto) begin
      if (dwell_q == DWELL_LAST) auto_sel_d = sel_next(auto_sel_q);
      else                       dwell_d    = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      auto_sel_q <= SEL_F0;
      dwell_q    <= '0;
    end else begin
      auto_sel_q <= auto_sel_d;
      dwell_q    <= dwell_d;
    end
  end

  assign target = i_auto ? auto_sel_q : sw_db;
`else
  logic unused_auto;
  assign unused_auto = i_auto;
  assign target      = sw_db;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    bcnt_d    = bcnt_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      S_OFF: begin
        if (i_enable) begin
          state_d = S_BLANK;
          pend_d  = target;
          bcnt_d  = '0;
        end
      end
      S_BLANK: begin
        if (!i_enable) begin
          state_d = S_OFF;
        end else if (target != pend_q) begin
          // Select moved again mid-gap: restart the full gap on the new value.
          pend_d = target;
          bcnt_d = '0;
        end else if (bcnt_q == BLANK_LAST) begin
          cur_sel_d = pend_q;
          state_d   = S_RUN;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Disable wins over a simultaneous select change.
        if (!i_enable) begin
          state_d = S_OFF;
        end else if (target != cur_sel_q) begin
          state_d = S_BLANK;
          pend_d  = target;
          bcnt_d  = '0;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs are registered from next-state so they align with the state flop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_OFF;
      pend_q     <= SEL_F0;
      bcnt_q     <= '0;
      cur_sel_q  <= SEL_F0;
      o_enable_q <= 1'b0;
      o_busy_q   <= 1'b0;
      o_sel_q    <= SEL_F0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      bcnt_q     <= bcnt_d;
      cur_sel_q  <= cur_sel_d;
      o_enable_q <= (state_d == S_RUN);
      o_busy_q   <= (state_d == S_BLANK);
      o_sel_q    <= cur_sel_d;
    end
  end

  assign o_enable   = o_enable_q;
  assign o_busy     = o_busy_q;
  assign o_switch_1 = o_sel_q[0];
  assign o_switch_2 = o_sel_q[1];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer (DEBOUNCE=4, BLANK=2, DWELL=16).
// Observed vector is {o_busy, o_enable, o_switch_2, o_switch_1}.
module tb_led_mode_sequencer;

  logic clk = 1'b0;
  logic rst, en, sw1, sw2, au;
  logic o_en, o_s1, o_s2, o_bsy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES   (2),
    .DWELL_CYCLES   (16),
    .CNT_W          (8)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_enable  (en),
    .i_switch_1(sw1),
    .i_switch_2(sw2),
    .i_auto    (au),
    .o_enable  (o_en),
    .o_switch_1(o_s1),
    .o_switch_2(o_s2),
    .o_busy    (o_bsy)
  );

  wire [3:0] obs = {o_bsy, o_en, o_s2, o_s1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance n edges, then sample 1 ns later.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] exp);
    tick(1);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    logic bad;
    rst = 1'b1; en = 1'b1; sw1 = 1'b1; sw2 = 1'b1; au = 1'b0;

    // 1: reset with switches 11 and enable high
    for (int i = 0; i < 3; i++) step_chk("rst_hold", 4'b0000);
    rst = 1'b0;
    step_chk("rst_e1", 4'b1000);
    step_chk("rst_e2", 4'b1000);
    step_chk("rst_e3_run", 4'b0100);
    tick(2);
    step_chk("rst_e6_run", 4'b0100);
    step_chk("rst_e7_blank", 4'b1000);
    step_chk("rst_e8_blank", 4'b1000);
    step_chk("rst_e9_run11", 4'b0111);

    // back to 00
    sw1 = 1'b0; sw2 = 1'b0;
    tick(12);
    chk("to00", 32'(obs), 32'(4'b0100));

    // 3: bounce on switch_1 shorter than debounce window is rejected
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw1 = i[1] ? 1'b0 : 1'b1;
      tick(1);
      if (obs != 4'b0100) bad = 1'b1;
    end
    sw1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (obs != 4'b0100) bad = 1'b1;
    end
    chk("bounce_reject", 32'(bad), 32'd0);

    // 2: clean 00 -> 01
    sw1 = 1'b1;
    tick(5);
    step_chk("c01_e6", 4'b0100);
    step_chk("c01_e7", 4'b1000);
    step_chk("c01_e8", 4'b1000);
    step_chk("c01_e9", 4'b0101);

    // 4: second switch lands during the gap -> gap restarts, goes straight to 11
    sw1 = 1'b0;
    tick(12);
    chk("re00", 32'(obs), 32'(4'b0100));
    sw1 = 1'b1;
    step_chk("ext_e1", 4'b0100);
    sw2 = 1'b1;
    for (int i = 2; i <= 6; i++) step_chk("ext_pre", 4'b0100);
    step_chk("ext_e7", 4'b1000);
    step_chk("ext_e8", 4'b1000);
    step_chk("ext_e9", 4'b1000);
    step_chk("ext_e10", 4'b0111);

    // 5: disable with simultaneous switch change; cur_sel held while off
    en = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
    step_chk("off_e1", 4'b0011);
    tick(11);
    chk("off_hold", 32'(obs), 32'(4'b0011));
    en = 1'b1;
    step_chk("on_e1", 4'b1011);
    step_chk("on_e2", 4'b1011);
    step_chk("on_e3", 4'b0100);

    // 6: auto-cycle
    au = 1'b1;
`ifdef LED_SEQ_AUTO_CYCLE_EN
    tick(16);
    step_chk("auto_b1", 4'b1000);
    tick(1);
    step_chk("auto_r1", 4'b0101);
    tick(16);
    step_chk("auto_b2", 4'b1001);
    tick(1);
    step_chk("auto_r2", 4'b0110);
    tick(16);
    step_chk("auto_b3", 4'b1010);
    tick(1);
    step_chk("auto_r3", 4'b0111);
    tick(16);
    step_chk("auto_b4", 4'b1011);
    tick(1);
    step_chk("auto_r0", 4'b0100);
`else
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (obs != 4'b0100) bad = 1'b1;
    end
    chk("auto_ignored", 32'(bad), 32'd0);
`endif

    // reset mid-RUN returns to reset values
    rst = 1'b1;
    step_chk("rst_mid", 4'b0000);
    rst = 1'b0; au = 1'b0;
    step_chk("rst_mid_e1", 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
